instr_ctrl: RTL and testbench

INSTR_CTRL -- requirements
Module: instr_ctrl

---
 rtl/ctrl_pkg.sv | 63 ++++++
 rtl/instr_ctrl_if.sv | 14 +
 rtl/instr_decode.sv | 68 ++++++
 rtl/instr_ctrl.sv | 126 ++++++++++++
 tb/tb_instr_ctrl.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the instruction controller.
//   state_t  - controller FSM states
//   alu_op_t - ALU function encodings driven on alu_op
//   ctrl_t   - decoded control bundle produced by instr_decode
//   map_reg  - 3-bit instruction register field to register-file select
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_IMM    = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_XOR = 3'd3,
    ALU_OR  = 3'd4
  } alu_op_t;

  // Opcodes with a fixed encoding
  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_INR_A = 8'h3C;
  localparam logic [7:0] OP_MVI_A = 8'h3E;
  localparam logic [7:0] OP_HLT   = 8'h76;

  // Register-file selects
  localparam logic [2:0] SEL_A   = 3'd0;
  localparam logic [2:0] SEL_ONE = 3'd7;  // port 2 only: constant 1

  // Memory-operand field value, not supported by this controller
  localparam logic [2:0] SSS_M = 3'b110;

  typedef struct packed {
    logic       en_a;    // load A from write-data path
    logic       st_alu;  // load A from ALU result
    logic       wr_src;  // 0 = imm_data, 1 = register port 1
    logic [2:0] op1;
    logic [2:0] op2;
    alu_op_t    alu;
    logic       ill;
  } ctrl_t;

  // B,C,D,E,H,L -> 1..6, A -> 0. The M code (110) has no register and
  // returns 0; callers flag it as illegal before using the result.
  function automatic logic [2:0] map_reg(input logic [2:0] sss);
    logic [2:0] sel;
    case (sss)
      3'b000:  sel = 3'd1;
      3'b001:  sel = 3'd2;
      3'b010:  sel = 3'd3;
      3'b011:  sel = 3'd4;
      3'b100:  sel = 3'd5;
      3'b101:  sel = 3'd6;
      default: sel = SEL_A;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/instr_ctrl_if.sv
// instr_ctrl_if: instruction-fetch bus between the controller and memory.
//   mem_addr  - fetch address (controller -> memory)
//   mem_rd    - fetch request, held until mem_ready (controller -> memory)
//   mem_data  - fetched byte, valid with mem_ready (memory -> controller)
//   mem_ready - fetch completion (memory -> controller)
interface instr_ctrl_if;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic        mem_ready;

  modport master (output mem_addr, mem_rd, input mem_data, mem_ready);
  modport slave  (input mem_addr, mem_rd, output mem_data, mem_ready);
endinterface

// File: rtl/instr_decode.sv
// instr_decode: purely combinational opcode-to-control decode.
//   ir   - instruction register (opcode byte)
//   ctrl - control bundle the controller applies during EXEC
// Unsupported opcodes and any M operand yield ill=1 with no strobes.
module instr_decode
  import ctrl_pkg::*;
(
  input  logic [7:0] ir,
  output ctrl_t      ctrl
);

  logic alu_ok;

  always_comb begin
    // NOTE: every output gets a default before the case so no path can
    // leave a value unassigned and infer a latch.
    ctrl   = '0;
    alu_ok = 1'b1;

    casez (ir)
      8'b01111???: begin  // MOV A,r
        if (ir[2:0] == SSS_M) begin
          ctrl.ill = 1'b1;
        end else begin
          ctrl.en_a   = 1'b1;
          ctrl.wr_src = 1'b1;
          ctrl.op1    = map_reg(ir[2:0]);
        end
      end

      OP_MVI_A: begin
        ctrl.en_a   = 1'b1;
        ctrl.wr_src = 1'b0;
      end

      OP_INR_A: begin
        ctrl.op1    = SEL_A;
        ctrl.op2    = SEL_ONE;
        ctrl.alu    = ALU_ADD;
        ctrl.st_alu = 1'b1;
      end

      OP_NOP: ;

      8'b10??????: begin  // ALU group, ooo in ir[5:3]
        case (ir[5:3])
          3'b000:  ctrl.alu = ALU_ADD;
          3'b010:  ctrl.alu = ALU_SUB;
          3'b100:  ctrl.alu = ALU_AND;
          3'b101:  ctrl.alu = ALU_XOR;
          3'b110:  ctrl.alu = ALU_OR;
          default: alu_ok = 1'b0;  // ADC/SBB/CMP not supported
        endcase
        if (alu_ok && ir[2:0] != SSS_M) begin
          ctrl.op1    = SEL_A;
          ctrl.op2    = map_reg(ir[2:0]);
          ctrl.st_alu = 1'b1;
        end else begin
          ctrl.alu = ALU_ADD;
          ctrl.ill = 1'b1;
        end
      end

      default: ctrl.ill = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_ctrl.sv
// instr_ctrl: fetch/decode/execute controller for an 8-bit accumulator core.
//   clk, rst        - clock, asynchronous active-high reset
//   mem             - fetch bus (instr_ctrl_if.master)
//   op1_select      - register-file port-1 select
//   op2_select      - register-file port-2 select (7 = constant 1)
//   alu_op          - ALU function
//   enable_reg_a    - strobe: load A from write-data path
//   store_alu_a_reg - strobe: load A from ALU result
//   wr_src          - write-data source (0 = imm_data, 1 = port 1)
//   imm_data        - immediate byte of MVI
//   halted          - high in HALT
//   illegal         - one-cycle pulse on an unsupported opcode
// Timing with mem_ready high: FETCH, DECODE, EXEC for one-byte opcodes;
// MVI adds two IMM cycles (fetch the byte, then present it on imm_data
// for a full cycle before the write strobe).
module instr_ctrl
  import ctrl_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                clk,
  input  logic                rst,
  instr_ctrl_if.master        mem,
  output logic [2:0]          op1_select,
  output logic [2:0]          op2_select,
  output logic [2:0]          alu_op,
  output logic                enable_reg_a,
  output logic                store_alu_a_reg,
  output logic                wr_src,
  output logic [7:0]          imm_data,
  output logic                halted,
  output logic                illegal
);

  state_t      state, state_next;
  logic [15:0] pc;
  logic [7:0]  ir;
  logic        imm_loaded;  // IMM byte captured, next cycle goes to EXEC
  ctrl_t       ctrl;

  instr_decode u_decode (
    .ir   (ir),
    .ctrl (ctrl)
  );

  // The address only matters while mem_rd is high; driving the PC at all
  // times keeps it stable across a stalled fetch.
  assign mem.mem_addr = pc;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_FETCH;
      pc         <= RESET_PC;
      ir         <= 8'h00;
      imm_data   <= 8'h00;
      imm_loaded <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_FETCH && mem.mem_ready) begin
        ir <= mem.mem_data;
        pc <= pc + 16'd1;  // wraps FFFF -> 0000
      end
      if (state == ST_IMM) begin
        if (imm_loaded) begin
          imm_loaded <= 1'b0;
        end else if (mem.mem_ready) begin
          imm_data   <= mem.mem_data;
          pc         <= pc + 16'd1;
          imm_loaded <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_next      = state;
    mem.mem_rd      = 1'b0;
    op1_select      = SEL_A;
    op2_select      = SEL_A;
    alu_op          = ALU_ADD;
    enable_reg_a    = 1'b0;
    store_alu_a_reg = 1'b0;
    wr_src          = 1'b0;
    halted          = 1'b0;
    illegal         = 1'b0;

    case (state)
      ST_FETCH: begin
        mem.mem_rd = 1'b1;
        if (mem.mem_ready) state_next = ST_DECODE;
      end

      ST_DECODE: begin
        if (ir == OP_MVI_A)   state_next = ST_IMM;
        else if (ir == OP_HLT) state_next = ST_HALT;
        else                   state_next = ST_EXEC;
      end

      ST_IMM: begin
        if (imm_loaded) begin
          state_next = ST_EXEC;
        end else begin
          mem.mem_rd = 1'b1;
        end
      end

      ST_EXEC: begin
        op1_select      = ctrl.op1;
        op2_select      = ctrl.op2;
        alu_op          = ctrl.alu;
        enable_reg_a    = ctrl.en_a;
        store_alu_a_reg = ctrl.st_alu;
        wr_src          = ctrl.wr_src;
        illegal         = ctrl.ill;
        state_next      = ST_FETCH;
      end

      ST_HALT: halted = 1'b1;  // left only through reset

      default: state_next = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_instr_ctrl.sv
// tb_instr_ctrl: self-checking bench for instr_ctrl. A byte-wide memory
// model feeds the fetch bus; expected EXEC events are queued when each
// program is loaded and popped by a monitor whenever a strobe or illegal
// pulse appears. Cycle n after reset release is sampled at its negedge.
module tb_instr_ctrl;
  import ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT 1: RESET_PC = 0000 ----------------
  instr_ctrl_if bus ();
  logic [7:0] mem [0:255];
  logic       ready_en = 1'b1;
  assign bus.mem_data  = mem[bus.mem_addr[7:0]];
  assign bus.mem_ready = ready_en;

  logic [2:0] op1_select, op2_select, alu_op;
  logic       enable_reg_a, store_alu_a_reg, wr_src, halted, illegal;
  logic [7:0] imm_data;

  instr_ctrl #(.RESET_PC(16'h0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem             (bus.master),
    .op1_select      (op1_select),
    .op2_select      (op2_select),
    .alu_op          (alu_op),
    .enable_reg_a    (enable_reg_a),
    .store_alu_a_reg (store_alu_a_reg),
    .wr_src          (wr_src),
    .imm_data        (imm_data),
    .halted          (halted),
    .illegal         (illegal)
  );

  // ---------------- DUT 2: RESET_PC = FFFF ----------------
  instr_ctrl_if bus2 ();
  assign bus2.mem_data  = (bus2.mem_addr == 16'hFFFF) ? 8'h00 : 8'h76;
  assign bus2.mem_ready = 1'b1;

  logic [2:0] op1_2, op2_2, alu_2;
  logic       en_a_2, st_alu_2, wr_src_2, halted_2, illegal_2;
  logic [7:0] imm_2;

  instr_ctrl #(.RESET_PC(16'hFFFF)) dut2 (
    .clk             (clk),
    .rst             (rst2),
    .mem             (bus2.master),
    .op1_select      (op1_2),
    .op2_select      (op2_2),
    .alu_op          (alu_2),
    .enable_reg_a    (en_a_2),
    .store_alu_a_reg (st_alu_2),
    .wr_src          (wr_src_2),
    .imm_data        (imm_2),
    .halted          (halted_2),
    .illegal         (illegal_2)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic       en_a;
    logic       st_alu;
    logic       ill;
    logic       wr_src;
    logic [2:0] op1;
    logic [2:0] op2;
    logic [2:0] alu;
    logic [7:0] imm;
  } ev_t;

  ev_t sb[$];

  function automatic ev_t ev_mvi(input logic [7:0] imm);
    ev_t e = '0;
    e.en_a = 1'b1;
    e.imm  = imm;
    return e;
  endfunction

  function automatic ev_t ev_mov(input logic [2:0] op1);
    ev_t e = '0;
    e.en_a   = 1'b1;
    e.wr_src = 1'b1;
    e.op1    = op1;
    return e;
  endfunction

  function automatic ev_t ev_alu(input logic [2:0] op2, input logic [2:0] alu);
    ev_t e = '0;
    e.st_alu = 1'b1;
    e.op2    = op2;
    e.alu    = alu;
    return e;
  endfunction

  function automatic ev_t ev_ill();
    ev_t e = '0;
    e.ill = 1'b1;
    return e;
  endfunction

  // Scoreboard monitor
  bit mon_en = 1'b0;
  always @(negedge clk) begin
    ev_t e;
    if (mon_en && !rst && (enable_reg_a || store_alu_a_reg || illegal)) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_event", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_enable_reg_a", enable_reg_a, e.en_a);
        check("sb_store_alu", store_alu_a_reg, e.st_alu);
        check("sb_illegal", illegal, e.ill);
        check("sb_wr_src", wr_src, e.wr_src);
        check("sb_op1", op1_select, e.op1);
        check("sb_op2", op2_select, e.op2);
        check("sb_alu_op", alu_op, e.alu);
        if (e.en_a && !e.wr_src) check("sb_imm", imm_data, e.imm);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic load(input logic [7:0] prog [], input int n);
    for (int i = 0; i < 256; i++) mem[i] = OP_HLT;
    for (int i = 0; i < n; i++) mem[i] = prog[i];
  endtask

  // Releases rst just after a rising edge: the next negedge is cycle 1.
  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_halt(input string tag, input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, halted, 1'b1);
  endtask

  logic [7:0] p [];

  initial begin
    // ---- reset state ----
    for (int i = 0; i < 256; i++) mem[i] = OP_HLT;
    repeat (2) @(negedge clk);
    check("rst_halted", halted, 1'b0);
    check("rst_enable_reg_a", enable_reg_a, 1'b0);
    check("rst_store_alu", store_alu_a_reg, 1'b0);
    check("rst_illegal", illegal, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 16'h0000);
    check("rst_imm_data", imm_data, 8'h00);
    check("rst_op_selects", {op1_select, op2_select, alu_op}, 9'd0);
    mon_en = 1'b1;

    // ---- MVI A,5A: strobe in cycle 5, next fetch at 0002 ----
    p = '{8'h3E, 8'h5A, 8'h76};
    load(p, 3);
    sb.push_back(ev_mvi(8'h5A));
    reset_dut();
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c < 5) check($sformatf("mvi_no_strobe_c%0d", c), enable_reg_a, 1'b0);
      if (c == 3) check("mvi_imm_fetch_addr", bus.mem_addr, 16'h0001);
      if (c == 5) begin
        check("mvi_enable_c5", enable_reg_a, 1'b1);
        check("mvi_wr_src_c5", wr_src, 1'b0);
        check("mvi_imm_c5", imm_data, 8'h5A);
      end
      if (c == 6) begin
        check("mvi_next_addr", bus.mem_addr, 16'h0002);
        check("mvi_next_rd", bus.mem_rd, 1'b1);
      end
    end
    wait_halt("mvi_halt", 20);
    check("mvi_sb_drained", sb.size(), 0);

    // ---- ADD B: store_alu in cycle 3 only ----
    p = '{8'h80, 8'h76};
    load(p, 2);
    sb.push_back(ev_alu(3'd1, 3'd0));
    reset_dut();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("add_store_c%0d", c), store_alu_a_reg, (c == 3));
      if (c == 2) check("add_op2_outside_exec", op2_select, 3'd0);
      if (c == 3) check("add_ops_c3", {op1_select, op2_select, alu_op}, {3'd0, 3'd1, 3'd0});
    end
    wait_halt("add_halt", 20);
    check("add_sb_drained", sb.size(), 0);

    // ---- INR A then HLT: halted holds, no fetch ----
    p = '{8'h3C, 8'h76};
    load(p, 2);
    sb.push_back(ev_alu(3'd7, 3'd0));
    reset_dut();
    wait_halt("inr_halt", 20);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("halt_halted", halted, 1'b1);
      check("halt_mem_rd", bus.mem_rd, 1'b0);
    end
    check("inr_sb_drained", sb.size(), 0);

    // ---- illegal opcodes 86 (ADD M) and 40 ----
    p = '{8'h86, 8'h40, 8'h00, 8'h76};
    load(p, 4);
    sb.push_back(ev_ill());
    sb.push_back(ev_ill());
    reset_dut();
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 3 || c == 6) check($sformatf("ill_pulse_c%0d", c), illegal, 1'b1);
      if (c == 4) check("ill_next_addr_1", bus.mem_addr, 16'h0001);
      if (c == 5) check("ill_no_pulse_c5", illegal, 1'b0);
      if (c == 7) check("ill_next_addr_2", bus.mem_addr, 16'h0002);
    end
    wait_halt("ill_halt", 20);
    check("ill_sb_drained", sb.size(), 0);

    // ---- mixed program through the scoreboard ----
    p = '{8'h3E, 8'h12, 8'hA8, 8'h90, 8'hA1, 8'hB5, 8'h7F, 8'h78, 8'h7E, 8'h00, 8'h76};
    load(p, 11);
    sb.push_back(ev_mvi(8'h12));
    sb.push_back(ev_alu(3'd1, 3'd3));  // XRA B
    sb.push_back(ev_alu(3'd1, 3'd1));  // SUB B
    sb.push_back(ev_alu(3'd2, 3'd2));  // ANA C
    sb.push_back(ev_alu(3'd6, 3'd4));  // ORA L
    sb.push_back(ev_mov(3'd0));        // MOV A,A
    sb.push_back(ev_mov(3'd1));        // MOV A,B
    sb.push_back(ev_ill());            // MOV A,M
    reset_dut();
    wait_halt("mix_halt", 80);
    check("mix_sb_drained", sb.size(), 0);

    // ---- stalled fetch, then reset mid-wait ----
    p = '{8'h00, 8'h78, 8'h76};
    load(p, 3);
    reset_dut();
    repeat (3) @(negedge clk);  // NOP executes in cycle 3
    ready_en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("stall_mem_rd", bus.mem_rd, 1'b1);
      check("stall_mem_addr", bus.mem_addr, 16'h0001);
    end
    #2 rst = 1'b1;
    #1;
    check("stall_rst_addr", bus.mem_addr, 16'h0000);
    check("stall_rst_no_strobe", {enable_reg_a, store_alu_a_reg, illegal}, 3'd0);
    ready_en = 1'b1;
    sb.push_back(ev_mov(3'd1));
    reset_dut();
    wait_halt("stall_halt", 30);
    check("stall_sb_drained", sb.size(), 0);

    // ---- RESET_PC = FFFF wraps to 0000 ----
    @(posedge clk);
    #1 rst2 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) check("wrap_first_addr", bus2.mem_addr, 16'hFFFF);
      if (c == 4) begin
        check("wrap_next_addr", bus2.mem_addr, 16'h0000);
        check("wrap_next_rd", bus2.mem_rd, 1'b1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
